prog_timer: RTL
===============

# prog_timer

Multi-channel programmable interval timer, the parametrised successor to the fixed-period tick generator. It provides N independent down-counters, each with a runtime-loadable period, a periodic or one-shot mode and a per-channel run enable. Each channel emits single-cycle tick pulses. It sits beside the core timing chain and serves as the shared timebase for I/O pacing (typewriter, photo-reader, punch) and for diagnostics.

## Interface
- `N`, default 4 — number of channels, 1..16.
- `W`, default 16 — counter/period width in bits, 2..32.
- `PRE`, default 108 — prescale divisor, ≥2; used only when the prescaler is compiled in.
- `clk` input 1 — single system clock; all logic is on its rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `ld` input 1 — load strobe, sampled every cycle.
- `ld_ch` input max(1,$clog2(N)) — channel to load; values ≥N are ignored.
- `ld_period` input W — period in steps; 0 encodes 2^W.
- `ld_oneshot` input 1 — 1 selects one-shot mode, 0 selects periodic mode.
- `en` input N — per-channel run enable, level-sensitive.
- `rd_ch` input max(1,$clog2(N)) — channel selected for readback.
- `rd_count` output W — combinational current counter of `rd_ch`; reads 0 when `rd_ch`≥N.
- `tick` output N — registered expiry pulses.
- `active` output N — registered; 1 while the channel is armed.

## Operation
- Per-channel state: `ctr`[W], `reload`[W], `oneshot`, `active`, `tick`.
- **Step:** `step` is 1 every cycle, or once per PRE cycles when the prescaler is compiled in (see Configuration).
- **Load** (when `ld` is set and `ld_ch`<N), for channel c = `ld_ch`:
  - `reload`←`ld_period`; `ctr`←`ld_period`−1 (mod 2^W); `oneshot`←`ld_oneshot`; `active`←1.
  - Load takes effect whether or not `en[c]` is set.
- **Count:** on an edge with `step`, `active[i]`, `en[i]` set and no load to channel i:
  - If `ctr`≠0, then `ctr`←`ctr`−1.
  - If `ctr`=0, then `tick[i]`←1. In periodic mode `ctr`←`reload`−1. In one-shot mode `active[i]`←0 and `ctr` holds at 0.
- **Tick default:** `tick[i]`←0 on every edge not covered by the expiry case above.
- **Hold:** when `en[i]`=0, `active[i]`=0, or `step`=0, `ctr` holds and no tick is produced.
- **Load vs expiry:** a load to a channel in the same cycle as its expiry wins. The counter reloads and no tick is issued that cycle.
- **Channel independence:** channels are fully independent. Loading one channel never disturbs another.

## Timing
- **Reset values:** `ctr`=0, `reload`=0, `oneshot`=0, `active`=0, `tick`=0, prescaler=PRE−1. Reset overrides `ld`. A reset mid-count aborts every channel with no tick.
- **Load-to-tick latency:** load captured at edge E0 with period P, `step` every cycle, `en` held at 1 → `tick` is high for exactly one cycle following edge E0+P.
  - Periodic mode: subsequent ticks follow every P cycles.
  - With the prescaler, the first tick arrives after P steps. Phase depends on prescaler position at load (0..PRE−1 cycles of slack).
- **Period 1:** `ctr` stays 0. Periodic mode gives `tick` high every step-cycle, i.e. continuously high without the prescaler.
- **Period 0:** period is 2^W steps. `ctr` wraps to all-ones at load.
- **Enable:** deasserting `en` freezes the count. Reasserting resumes with no lost or extra step.
- **Outputs:** `active` falls in the same cycle the one-shot `tick` rises.

## Configuration
- Macro: `G15_TIMER_PRESCALE_EN`.
- **Defined:** a shared prescaler counter counts down from PRE−1, with `step`=1 when it is 0, then it reloads PRE−1. It free-runs from reset and is not affected by `ld` or `en`.
- **Undefined:** there is no prescaler logic, `step` is tied to 1, and `PRE` is ignored.

## Test plan
- **Periodic:** N=4, W=16, no prescale; load ch1 P=5 periodic, `en`=4'b0010 → `tick[1]` high one cycle after E5, E10, E15; other ticks stay 0; `active[1]`=1 throughout.
- **One-shot:** load ch0 P=3 one-shot → a single `tick[0]` after E3; `active[0]` drops with it; `rd_count`(ch0)=0 afterwards; no further ticks over 20 cycles.
- **Enable gating and boundary periods:**
  - Ch2 P=4; drop `en[2]` for 7 cycles after E2 → tick delayed to E11, with `rd_count` held at 1 during the gap.
  - P=1 periodic → `tick` high continuously.
  - P=0, W=4 → ticks every 16 cycles.
- **Collisions:**
  - Reload ch3 with P=6 on its expiry cycle → no tick; next tick 6 cycles later.
  - Simultaneous `ld` with `ld_ch`=N → ignored.
- **Reset mid-operation:** assert `rst` while all channels count → every output 0 on the next cycle; `ld` asserted during `rst` is ignored.
- **Prescaler** (`G15_TIMER_PRESCALE_EN`, PRE=108): ch0 P=2 periodic → ticks exactly 216 cycles apart; the first tick lands within 108–215 cycles of the load.

Source files
------------

// File: rtl/prog_timer.sv
// Multi-channel programmable interval timer: N independent down-counters with
// loadable period, periodic/one-shot mode and run enable. Optional shared prescaler
// is compiled in with the macro G15_TIMER_PRESCALE_EN.
module prog_timer #(
  parameter int N   = 4,
  parameter int W   = 16,
  parameter int PRE = 108,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [CW-1:0] ld_ch,
  input  logic [W-1:0]  ld_period,
  input  logic          ld_oneshot,
  input  logic [N-1:0]  en,
  input  logic [CW-1:0] rd_ch,
  output logic [W-1:0]  rd_count,
  output logic [N-1:0]  tick,
  output logic [N-1:0]  active
);

  if (N < 1 || N > 16 || W < 2 || W > 32 || PRE < 2) begin : g_param_check
    $error("prog_timer: parameter out of range");
  end

  logic [W-1:0] r_ctr    [N];
  logic [W-1:0] r_reload [N];
  logic [N-1:0] r_oneshot;
  logic [N-1:0] r_active;
  logic [N-1:0] r_tick;
  logic         w_step;

`ifdef G15_TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRE);
  logic [PW-1:0] r_pre;

  // Free-running divider: unaffected by loads or enables.
  always_ff @(posedge clk) begin
    if (rst)                r_pre <= PW'(PRE - 1);
    else if (r_pre == '0)   r_pre <= PW'(PRE - 1);
    else                    r_pre <= r_pre - 1'b1;
  end

  assign w_step = (r_pre == '0);
`else
  assign w_step = 1'b1;
`endif

  // NOTE: the counter arrays are only a handful of flops per channel, so they
  // are reset like ordinary registers rather than treated as uninitialised RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_ctr[i]    <= '0;
        r_reload[i] <= '0;
      end
      r_oneshot <= '0;
      r_active  <= '0;
      r_tick    <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        // NOTE: non-blocking assignments throughout, so the default clear of
        // r_tick below is simply overridden by a later expiry in the same pass.
        r_tick[i] <= 1'b0;
        if (ld && (ld_ch == CW'(i))) begin
          // A load always wins over a coincident expiry; no tick that cycle.
          r_reload[i]  <= ld_period;
          r_ctr[i]     <= ld_period - 1'b1;
          r_oneshot[i] <= ld_oneshot;
          r_active[i]  <= 1'b1;
        end else if (w_step && r_active[i] && en[i]) begin
          if (r_ctr[i] != '0) begin
            r_ctr[i] <= r_ctr[i] - 1'b1;
          end else begin
            r_tick[i] <= 1'b1;
            if (r_oneshot[i]) r_active[i] <= 1'b0;
            else              r_ctr[i]    <= r_reload[i] - 1'b1;
          end
        end
      end
    end
  end

  // Out-of-range selects match no channel and read back as zero.
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_ch == CW'(i)) rd_count = r_ctr[i];
    end
  end

  assign tick   = r_tick;
  assign active = r_active;

endmodule
